// File: rtl/pc_fetch.sv
// Program counter and IF/ID pipeline register for a single-issue fetch stage.
// Redirects come from the instruction in ID; fetched words land in ID one cycle later.
module pc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [15:0] branch_imm,
  input  logic        jump_en,
  input  logic [25:0] jump_idx,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        addr_err
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        take_jump;
  logic        take_branch;

  assign imem_addr = pc;
  assign addr_err  = (pc[1:0] != 2'b00) || (pc > LAST_WORD);
  assign pc_plus4  = pc + 32'd4;

  assign branch_target = id_pc4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign jump_target   = {id_pc4[31:28], jump_idx, 2'b00};

  // A bubble in ID carries no instruction, so it can never redirect fetch.
  assign take_jump   = jump_en & id_valid;
  assign take_branch = branch_en & id_valid & ~take_jump;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      id_instr <= 32'd0;
      id_pc4   <= 32'd0;
      id_valid <= 1'b0;
    end else if (take_jump || take_branch) begin
      pc       <= take_jump ? jump_target : branch_target;
      id_instr <= 32'd0;
      id_pc4   <= 32'd0;
      id_valid <= 1'b0;
    end else if (!stall) begin
      pc       <= pc_plus4;
      id_instr <= addr_err ? 32'd0 : imem_data;
      id_pc4   <= pc_plus4;
      id_valid <= ~addr_err;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: each applied cycle pushes the expected
// post-edge state, which is popped and compared one time unit after the edge.
module tb_pc_fetch;

  localparam int MEM_BYTES = 256;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        err;
    logic        chk_pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic [15:0] branch_imm = 16'd0;
  logic        jump_en = 1'b0;
  logic [25:0] jump_idx = 26'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        addr_err;

  logic [7:0] mem [MEM_BYTES];
  exp_t       sb [$];
  int         vectors = 0;
  int         miscompares = 0;
  int         step = 0;

  pc_fetch #(.RESET_PC(32'h0000_0000), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en),
    .branch_imm(branch_imm), .jump_en(jump_en), .jump_idx(jump_idx),
    .imem_addr(imem_addr), .imem_data(imem_data), .id_instr(id_instr),
    .id_pc4(id_pc4), .id_valid(id_valid), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a > 32'(MEM_BYTES - 4))
      return 32'hDEAD_BEEF;
    return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
  endfunction

  // Out-of-range reads return garbage so the bench can see it being discarded.
  assign imem_data = memWord(imem_addr);

  function automatic exp_t mk(input logic [31:0] addr, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid,
                              input logic err, input logic chk_pc4);
    exp_t e;
    e.addr = addr; e.instr = instr; e.pc4 = pc4;
    e.valid = valid; e.err = err; e.chk_pc4 = chk_pc4;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic be,
                               input logic [15:0] imm, input logic je,
                               input logic [25:0] idx, input exp_t e);
    exp_t x;
    rst = r; stall = s; branch_en = be; branch_imm = imm;
    jump_en = je; jump_idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step++;
    x = sb.pop_front();
    checkOutput($sformatf("s%0d.imem_addr", step), imem_addr, x.addr);
    checkOutput($sformatf("s%0d.id_instr", step), id_instr, x.instr);
    checkOutput($sformatf("s%0d.id_valid", step), {31'd0, id_valid}, {31'd0, x.valid});
    checkOutput($sformatf("s%0d.addr_err", step), {31'd0, addr_err}, {31'd0, x.err});
    if (x.chk_pc4)
      checkOutput($sformatf("s%0d.id_pc4", step), id_pc4, x.pc4);
  endtask

  task automatic advance(input logic [31:0] addr, input logic [31:0] instr,
                         input logic [31:0] pc4, input logic valid, input logic err);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, mk(addr, instr, pc4, valid, err, 1'b1));
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] prev;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'(i * 7 + 3);
    {mem[0],  mem[1],  mem[2],  mem[3]}  = 32'h0011_10AA;
    {mem[4],  mem[5],  mem[6],  mem[7]}  = 32'h0011_15AA;
    {mem[8],  mem[9],  mem[10], mem[11]} = 32'h0022_10BB;
    {mem[12], mem[13], mem[14], mem[15]} = 32'h0033_10CC;

    // Reset, free-run, three-cycle stall, resume.
    doReset();
    advance(32'd4,  32'h0011_10AA, 32'd4,  1'b1, 1'b0);
    advance(32'd8,  32'h0011_15AA, 32'd8,  1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 26'd0,
                    mk(32'd8, 32'h0011_15AA, 32'd8, 1'b1, 1'b0, 1'b1));
    advance(32'd12, 32'h0022_10BB, 32'd12, 1'b1, 1'b0);

    // Backward branch from id_pc4=8 to 0, then branch_en held over the bubble is ignored.
    doReset();
    advance(32'd4, 32'h0011_10AA, 32'd4, 1'b1, 1'b0);
    advance(32'd8, 32'h0011_15AA, 32'd8, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'd0,
                  mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'd0,
                  mk(32'd4, 32'h0011_10AA, 32'd4, 1'b1, 1'b0, 1'b1));
    advance(32'd8, 32'h0011_15AA, 32'd8, 1'b1, 1'b0);

    // Jump and branch together: jump to word 3 wins.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b1, 26'd3,
                  mk(32'd12, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
    advance(32'd16, 32'h0033_10CC, 32'd16, 1'b1, 1'b0);

    // Reset beats stall, branch and jump asserted in the same cycle.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b1, 26'd3,
                  mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1));

    // Branch under stall to 0xFFFFFFFC, then PC wraps to 0.
    advance(32'd4, 32'h0011_10AA, 32'd4, 1'b1, 1'b0);
    advance(32'd8, 32'h0011_15AA, 32'd8, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFD, 1'b0, 26'd0,
                  mk(32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0));
    advance(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    advance(32'd4, 32'h0011_10AA, 32'd4, 1'b1, 1'b0);

    // Free-run from reset past the end of memory.
    doReset();
    for (int n = 1; n <= 66; n++) begin
      prev = 32'(4 * (n - 1));
      if (prev <= 32'(MEM_BYTES - 4))
        advance(32'(4 * n), memWord(prev), 32'(4 * n), 1'b1, (32'(4 * n) > 32'(MEM_BYTES - 4)));
      else
        advance(32'(4 * n), 32'd0, 32'(4 * n), 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address loaded into PC on reset.
REQ-002 SHALL have parameter MEM_BYTES, default 256, size of the byte-addressed instruction memory.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port stall, input, 1, hold PC and IF/ID register.
REQ-006 SHALL have port branch_en, input, 1, take a branch for the instruction currently in ID.
REQ-007 SHALL have port branch_imm, input, 16, signed word offset of the branch.
REQ-008 SHALL have port jump_en, input, 1, take a jump for the instruction currently in ID.
REQ-009 SHALL have port jump_idx, input, 26, jump word index.
REQ-010 SHALL have port imem_addr, output, 32, byte address to instruction memory read port.
REQ-011 SHALL have port imem_data, input, 32, big-endian instruction word returned combinationally for imem_addr.
REQ-012 SHALL have port id_instr, output, 32, registered instruction for decode.
REQ-013 SHALL have port id_pc4, output, 32, registered address of the ID instruction plus 4.
REQ-014 SHALL have port id_valid, output, 1, id_instr holds a real instruction.
REQ-015 SHALL have port addr_err, output, 1, current PC is misaligned or outside memory.

Function
REQ-016 SHALL drive imem_addr combinationally equal to the PC register.
REQ-017 SHALL assert addr_err combinationally when PC[1:0]!=0 or PC > MEM_BYTES-4.
REQ-018 SHALL compute branch target = id_pc4 + (sign-extend(branch_imm) << 2), modulo 2^32.
REQ-019 SHALL compute jump target = {id_pc4[31:28], jump_idx, 2'b00}.
REQ-020 SHALL apply next-PC priority per edge: rst > jump_en > branch_en > stall > PC+4 (modulo 2^32).
REQ-021 SHALL, on jump or branch redirect, load the target into PC and load IF/ID with bubble (id_instr=0, id_valid=0), regardless of stall.
REQ-022 SHALL, on stall without redirect, hold PC, id_instr, id_pc4, id_valid unchanged.
REQ-023 SHALL, on normal advance, load id_instr<=imem_data, id_pc4<=PC+4, id_valid<=!addr_err; if addr_err, id_instr<=0.
REQ-024 SHALL ignore branch_en and jump_en when id_valid=0.
REQ-025 SHALL keep fetch latency at one cycle: word at PC appears on id_instr the edge after PC is presented.
REQ-026 SHALL wrap PC from 32'hFFFF_FFFC to 32'h0000_0000 without other side effect.
REQ-027 SHALL continue advancing past an addr_err PC; no trap or halt state.

Reset
REQ-028 SHALL, when rst=1 at a rising edge, set PC=RESET_PC, id_instr=0, id_pc4=0, id_valid=0.
REQ-029 SHALL give rst priority over stall, branch_en and jump_en in the same cycle.
REQ-030 SHALL present a bubble in ID for the first cycle after reset release.
REQ-031 SHALL clear a redirect in progress when reset occurs mid-operation; no pending state survives reset.

Verification
Memory preloaded with bytes forming words 0x001110AA@0, 0x001115AA@4, 0x002210BB@8, 0x003310CC@12.
REQ-032 SHALL cover reset then free-run: imem_addr 0,4,8,12 on successive cycles; id_instr 0x001110AA/id_pc4=4, then 0x001115AA/8, then 0x002210BB/12; id_valid=0 first cycle.
REQ-033 SHALL cover stall for 3 cycles with PC=8: imem_addr stays 8, id_instr stays 0x001115AA, id_pc4 stays 8; resumes with 0x002210BB.
REQ-034 SHALL cover branch with id_pc4=8, branch_imm=16'hFFFE: next PC=0, ID bubble (id_valid=0), following cycle id_instr=0x001110AA.
REQ-035 SHALL cover jump_en and branch_en both set, jump_idx=3, id_pc4=8: next PC=12 (jump wins), then id_instr=0x003310CC.
REQ-036 SHALL cover stall with branch and rst asserted together: PC=RESET_PC, id_valid=0; and PC reaching 256: addr_err=1, id_valid=0, id_instr=0.
